// File: rtl/tuart_pkg.sv
// Shared types and default constants for the tuart transmitter.
package tuart_pkg;

  localparam int TUART_CYCLES_PER_BIT = 10;
  localparam int TUART_WORD_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tuart_tx_state_t;

endpackage

// File: rtl/tuart_bit_timer.sv
// Bit-period timer: counts 0..CYCLES_PER_BIT-1, pulses tc on the last count
// and wraps to 0. clr holds the count at 0.
module tuart_bit_timer
  import tuart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = TUART_CYCLES_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr,
  output logic tc
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);

  logic [CNT_W-1:0] count_q;

  assign tc = (count_q == CNT_W'(CYCLES_PER_BIT - 1));

  // Modulo counter with synchronous clear.
  always_ff @(posedge clk_i or posedge rst_in) begin
    if (rst_in)         count_q <= '0;
    else if (clr || tc) count_q <= '0;
    else                count_q <= count_q + 1'b1;
  end

endmodule

// File: rtl/tuart_tx.sv
// UART transmitter: one byte per accepted request, framed as start bit,
// WORD_BITS data bits LSB first, optional even parity, stop bit.
// Build option: define TUART_TX_PARITY_EN to insert an even-parity bit (8E1).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high, ready; a request loads the shift register
// START  | line low for one bit period
// DATA   | line = shift register bit 0, shift right each bit period
// PARITY | line = XOR of the latched byte (only with TUART_TX_PARITY_EN)
// STOP   | line high for one bit period; a request at its end chains a
//        | new frame with no idle gap
module tuart_tx
  import tuart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = TUART_CYCLES_PER_BIT,
  parameter int WORD_BITS      = TUART_WORD_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic [WORD_BITS-1:0] data_i,
  input  logic                 stb_i,
  output logic                 rdy_o,
  output logic                 tx_o
);

  localparam int IDX_W = $clog2(WORD_BITS + 1);

  tuart_tx_state_t      state_q, state_n;
  logic [WORD_BITS-1:0] shift_q, shift_n, shift_dn;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 tx_q, tx_n;
  logic                 bit_tc;
  logic                 timer_clr;
  logic                 accept;
`ifdef TUART_TX_PARITY_EN
  logic                 parity_q;
`endif

  assign shift_dn  = shift_q >> 1;
  assign timer_clr = (state_q == IDLE);
  assign rdy_o     = (state_q == IDLE);
  assign tx_o      = tx_q;

  tuart_bit_timer #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_bit_timer (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .clr   (timer_clr),
    .tc    (bit_tc)
  );

  // State, datapath and registered line level.
  always_ff @(posedge clk_i or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      idx_q   <= idx_n;
      tx_q    <= tx_n;
    end
  end

`ifdef TUART_TX_PARITY_EN
  // Parity of the byte is captured once, when the byte is accepted.
  always_ff @(posedge clk_i or posedge rst_in) begin
    if (rst_in)      parity_q <= 1'b0;
    else if (accept) parity_q <= ^data_i;
  end
`endif

  // Next-state logic; tx_n is the line level for the coming cycle so the
  // output comes straight from a flop.
  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    idx_n   = idx_q;
    tx_n    = tx_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_n = 1'b1;
        if (stb_i) accept = 1'b1;
      end
      START: begin
        if (bit_tc) begin
          state_n = DATA;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tc) begin
          shift_n = shift_dn;
          idx_n   = idx_q + 1'b1;
          if (idx_q == IDX_W'(WORD_BITS - 1)) begin
`ifdef TUART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = parity_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            tx_n = shift_dn[0];
          end
        end
      end
      PARITY: begin
        if (bit_tc) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_tc) begin
          if (stb_i) begin
            accept = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
    if (accept) begin
      state_n = START;
      shift_n = data_i;
      idx_n   = '0;
      tx_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_tuart_tx.sv
// Self-checking bench for tuart_tx: frames are compared per bit slot
// against a model that lists the expected line level of every slot.
module tb_tuart_tx;

  localparam int C = 10;
  localparam int W = 8;
`ifdef TUART_TX_PARITY_EN
  localparam int NS = W + 3;
`else
  localparam int NS = W + 2;
`endif
  localparam int FC = NS * C;

  logic         clk_i  = 1'b0;
  logic         rst_in = 1'b1;
  logic         stb_i  = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         rdy_o;
  logic         tx_o;

  int errors = 0;
  int checks = 0;

  logic tx_s  [0:511];
  logic rdy_s [0:511];

  tuart_tx #(
    .CYCLES_PER_BIT(C),
    .WORD_BITS     (W)
  ) dut (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .data_i(data_i),
    .stb_i (stb_i),
    .rdy_o (rdy_o),
    .tx_o  (tx_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected line level of slot k of a frame carrying d.
  function automatic logic model_bit(input logic [W-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= W) return d[k-1];
`ifdef TUART_TX_PARITY_EN
    if (k == W + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic int slot_errs(input int base, input logic [W-1:0] d, input int k);
    int e = 0;
    for (int j = 0; j < C; j++)
      if (tx_s[base + k*C + j] !== model_bit(d, k)) e++;
    return e;
  endfunction

  function automatic logic [W-1:0] mid_byte(input int base);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) r[b] = tx_s[base + (b+1)*C + C/2];
    return r;
  endfunction

  function automatic int count_low(input int first, input int n, input logic use_rdy);
    int e = 0;
    for (int i = first; i < first + n; i++)
      if ((use_rdy ? rdy_s[i] : tx_s[i]) !== 1'b1) e++;
    return e;
  endfunction

  function automatic int count_high_rdy(input int first, input int n);
    int e = 0;
    for (int i = first; i < first + n; i++) if (rdy_s[i] !== 1'b0) e++;
    return e;
  endfunction

  // Records n negedge samples starting at index first.
  task automatic capture(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      tx_s[i]  = tx_o;
      rdy_s[i] = rdy_o;
      @(negedge clk_i);
    end
  endtask

  // Presents a request at a negedge; returns one negedge after the
  // accepting edge (sample 1 of the frame) with stb_i/data_i updated.
  task automatic start_req(input logic [W-1:0] d, input logic keep, input logic [W-1:0] after);
    int n = 0;
    while (rdy_o !== 1'b1 && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (rdy_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL start_req_timeout: rdy_o=%b required 1", rdy_o);
    end
    data_i = d;
    stb_i  = 1'b1;
    @(negedge clk_i);
    data_i = after;
    stb_i  = keep;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    stb_i  = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      checks++;
      if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx_o); end
      checks++;
      if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b required 1", rdy_o); end
    end
    rst_in = 1'b0;
    @(negedge clk_i);
    capture(1, 20);
    checks++;
    if (count_low(1, 20, 1'b0) !== 0) begin
      errors++; $display("FAIL idle_tx: %0d low cycles, required 0", count_low(1, 20, 1'b0));
    end
    checks++;
    if (count_low(1, 20, 1'b1) !== 0) begin
      errors++; $display("FAIL idle_rdy: %0d low cycles, required 0", count_low(1, 20, 1'b1));
    end
  endtask

  // One frame; data_i is scrambled right after acceptance.
  task automatic test_frame(input logic [W-1:0] d);
    int e;
    start_req(d, 1'b0, ~d);
    capture(1, FC + 1);
    for (int k = 0; k < NS; k++) begin
      e = slot_errs(1, d, k);
      checks++;
      if (e !== 0) begin
        errors++;
        $display("FAIL frame_%02h_slot%0d: %0d cycles wrong, mid level %b required %b",
                 d, k, e, tx_s[1 + k*C + C/2], model_bit(d, k));
      end
    end
    checks++;
    if (mid_byte(1) !== d) begin
      errors++; $display("FAIL frame_byte: got %02h required %02h", mid_byte(1), d);
    end
    checks++;
    if (count_high_rdy(1, FC) !== 0) begin
      errors++; $display("FAIL frame_rdy_busy: %0d ready cycles in frame, required 0", count_high_rdy(1, FC));
    end
    checks++;
    if (rdy_s[FC+1] !== 1'b1 || tx_s[FC+1] !== 1'b1) begin
      errors++; $display("FAIL frame_end: rdy=%b tx=%b required 1 1", rdy_s[FC+1], tx_s[FC+1]);
    end
  endtask

  task automatic test_bit_order();
    logic [W-1:0] d;
    d = 8'hA5;
    start_req(d, 1'b0, 8'h00);
    capture(1, FC + 1);
    checks++;
    if (tx_s[1 + C/2] !== 1'b0) begin errors++; $display("FAIL order_start: got %b required 0", tx_s[1 + C/2]); end
    checks++;
    if (mid_byte(1) !== d) begin errors++; $display("FAIL order_byte: got %02h required %02h", mid_byte(1), d); end
    checks++;
    if (tx_s[1 + (NS-1)*C + C/2] !== 1'b1) begin
      errors++; $display("FAIL order_stop: got %b required 1", tx_s[1 + (NS-1)*C + C/2]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    repeat (6) begin
      d = W'($urandom);
      test_frame(d);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [W-1:0] d1, d2;
    d1 = 8'h0F;
    d2 = 8'hF0;
    start_req(d1, 1'b1, d2);
    for (int i = 1; i <= 2*FC + C; i++) begin
      tx_s[i]  = tx_o;
      rdy_s[i] = rdy_o;
      if (i == FC + FC/2) stb_i = 1'b0;
      @(negedge clk_i);
    end
    for (int k = 0; k < NS; k++) begin
      e = slot_errs(1, d1, k);
      checks++;
      if (e !== 0) begin errors++; $display("FAIL b2b_first_slot%0d: %0d cycles wrong, required 0", k, e); end
      e = slot_errs(FC + 1, d2, k);
      checks++;
      if (e !== 0) begin errors++; $display("FAIL b2b_second_slot%0d: %0d cycles wrong, required 0", k, e); end
    end
    checks++;
    if (count_high_rdy(1, 2*FC) !== 0) begin
      errors++; $display("FAIL b2b_rdy: %0d ready cycles across both frames, required 0", count_high_rdy(1, 2*FC));
    end
    checks++;
    if (count_low(2*FC + 1, C, 1'b0) !== 0 || rdy_s[2*FC + C] !== 1'b1) begin
      errors++; $display("FAIL b2b_third_frame: %0d low tx cycles after, rdy=%b, required 0 and 1",
                         count_low(2*FC + 1, C, 1'b0), rdy_s[2*FC + C]);
    end
    // A one-cycle request mid-frame must be dropped.
    start_req(8'h5A, 1'b0, 8'h00);
    repeat (4*C) @(negedge clk_i);
    data_i = 8'hFF; stb_i = 1'b1;
    @(negedge clk_i);
    stb_i = 1'b0;
    repeat (FC - 4*C - 1) @(negedge clk_i);
    capture(1, 3*C);
    checks++;
    if (count_low(1, 3*C, 1'b0) !== 0) begin
      errors++; $display("FAIL busy_ignore: %0d low tx cycles after frame, required 0", count_low(1, 3*C, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    start_req(8'h00, 1'b0, 8'h00);
    repeat (4*C + C/2) @(negedge clk_i);
    rst_in = 1'b1;
    #1;
    checks++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b required 1", tx_o); end
    checks++;
    if (rdy_o !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy: got %b required 1", rdy_o); end
    repeat (2) @(negedge clk_i);
    rst_in = 1'b0;
    @(negedge clk_i);
    test_frame(8'h3C);
  endtask

`ifdef TUART_TX_PARITY_EN
  task automatic test_parity();
    test_frame(8'h07);
    checks++;
    if (tx_s[1 + (W+1)*C + C/2] !== 1'b1) begin
      errors++; $display("FAIL parity_07: got %b required 1", tx_s[1 + (W+1)*C + C/2]);
    end
    test_frame(8'h03);
    checks++;
    if (tx_s[1 + (W+1)*C + C/2] !== 1'b0) begin
      errors++; $display("FAIL parity_03: got %b required 0", tx_s[1 + (W+1)*C + C/2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame(8'h55);
    test_bit_order();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef TUART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
